readout_rx_state_counter: RTL and testbench

//  Downstream of the readout bin classifier. Over each readout window it counts the valid samples,
//  and counts separately the valid samples whose count_condition is 1 (|1> bin). When the window

---
 rtl/readout_rx_state_counter_if.sv | 32 +++
 rtl/readout_rx_state_counter.sv | 102 ++++++++++
 tb/tb_readout_rx_state_counter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/readout_rx_state_counter_if.sv
// Sample/config/decision bundle between the readout classifier, the state counter and its consumer.
// Signal directions are named from the counter's point of view.
interface readout_rx_state_counter_if #(
   parameter int unsigned COUNT_WIDTH    = 16,
   parameter int unsigned CFG_ADDR_WIDTH = 1
);
   logic                      i_cfg_wr_en;
   logic [CFG_ADDR_WIDTH-1:0] i_cfg_wr_addr;
   logic [COUNT_WIDTH-1:0]    i_cfg_wr_data;
   logic                      i_start_count;
   logic                      i_finish_count;
   logic                      i_valid;
   logic                      i_count_condition;
   logic                      o_busy;
   logic                      o_state_valid;
   logic                      o_state_out;
   logic [COUNT_WIDTH-1:0]    o_one_count;
   logic [COUNT_WIDTH-1:0]    o_sample_count;
   logic                      o_empty_window;

   modport master (
      output i_cfg_wr_en, i_cfg_wr_addr, i_cfg_wr_data,
      output i_start_count, i_finish_count, i_valid, i_count_condition,
      input  o_busy, o_state_valid, o_state_out, o_one_count, o_sample_count, o_empty_window
   );

   modport slave (
      input  i_cfg_wr_en, i_cfg_wr_addr, i_cfg_wr_data,
      input  i_start_count, i_finish_count, i_valid, i_count_condition,
      output o_busy, o_state_valid, o_state_out, o_one_count, o_sample_count, o_empty_window
   );
endinterface

// File: rtl/readout_rx_state_counter.sv
// Per-window |1> sample counter with threshold decision; one registered qubit-state result per window.
// Counters saturate; a start pulse in any state (re)opens a window with fresh counts.
module readout_rx_state_counter #(
   parameter int unsigned COUNT_WIDTH    = 16,
   parameter int unsigned CFG_ADDR_WIDTH = 1,
   parameter int unsigned THRESHOLD_INIT = 0
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   readout_rx_state_counter_if.slave   io_bus
);
   localparam int unsigned CW = COUNT_WIDTH;
   localparam int unsigned AW = CFG_ADDR_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DECIDE} state_t;

   state_t        r_state;
   logic [CW-1:0] r_sample_cnt;
   logic [CW-1:0] r_one_cnt;
   logic [CW-1:0] r_threshold;
   logic [CW-1:0] r_max_samples;
   logic          r_busy;
   logic          r_state_valid;
   logic          r_state_out;
   logic [CW-1:0] r_one_count_out;
   logic [CW-1:0] r_sample_count_out;
   logic          r_empty_window;

   logic          w_active;
   logic          w_hit;
   logic [CW-1:0] w_sample_base;
   logic [CW-1:0] w_one_base;
   logic [CW-1:0] w_sample_upd;
   logic [CW-1:0] w_one_upd;
   logic          w_close;
   logic          w_thr_wr;
   logic [CW-1:0] w_thr_eff;

   // A start pulse opens or restarts a window from any state, including DECIDE.
   assign w_active      = io_bus.i_start_count || (r_state == S_COUNT);
   assign w_hit         = io_bus.i_valid && io_bus.i_count_condition;
   assign w_sample_base = io_bus.i_start_count ? '0 : r_sample_cnt;
   assign w_one_base    = io_bus.i_start_count ? '0 : r_one_cnt;
   assign w_sample_upd  = (io_bus.i_valid && (w_sample_base != '1)) ? w_sample_base + CW'(1)
                                                                     : w_sample_base;
   assign w_one_upd     = (w_hit && (w_one_base != '1)) ? w_one_base + CW'(1) : w_one_base;
   assign w_close       = w_active && (io_bus.i_finish_count ||
                          ((r_max_samples != '0) && (w_sample_upd == r_max_samples)));

   // The decision sees the threshold as it stands during the DECIDE cycle, so a
   // write landing on the closing edge is forwarded.
   assign w_thr_wr  = io_bus.i_cfg_wr_en && (io_bus.i_cfg_wr_addr == AW'(0));
   assign w_thr_eff = w_thr_wr ? io_bus.i_cfg_wr_data : r_threshold;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state            <= S_IDLE;
         r_sample_cnt       <= '0;
         r_one_cnt          <= '0;
         r_threshold        <= CW'(THRESHOLD_INIT);
         r_max_samples      <= '0;
         r_busy             <= 1'b0;
         r_state_valid      <= 1'b0;
         r_state_out        <= 1'b0;
         r_one_count_out    <= '0;
         r_sample_count_out <= '0;
         r_empty_window     <= 1'b0;
      end else begin
         r_state_valid <= 1'b0;
         if (io_bus.i_cfg_wr_en) begin
            if (io_bus.i_cfg_wr_addr == AW'(0)) r_threshold   <= io_bus.i_cfg_wr_data;
            else                                r_max_samples <= io_bus.i_cfg_wr_data;
         end
         if (w_active) begin
            r_sample_cnt <= w_sample_upd;
            r_one_cnt    <= w_one_upd;
         end
         if (w_close) begin
            r_state            <= S_DECIDE;
            r_state_valid      <= 1'b1;
            r_state_out        <= (w_one_upd >= w_thr_eff);
            r_one_count_out    <= w_one_upd;
            r_sample_count_out <= w_sample_upd;
            r_empty_window     <= (w_sample_upd == '0);
            r_busy             <= 1'b0;
         end else if (w_active) begin
            r_state <= S_COUNT;
            r_busy  <= 1'b1;
         end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
         end
      end
   end

   assign io_bus.o_busy         = r_busy;
   assign io_bus.o_state_valid  = r_state_valid;
   assign io_bus.o_state_out    = r_state_out;
   assign io_bus.o_one_count    = r_one_count_out;
   assign io_bus.o_sample_count = r_sample_count_out;
   assign io_bus.o_empty_window = r_empty_window;
endmodule

// File: tb/tb_readout_rx_state_counter.sv
// Directed bench for readout_rx_state_counter: a 16-bit instance for the main flows and a 4-bit
// instance for counter saturation.
module tb_readout_rx_state_counter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   readout_rx_state_counter_if #(.COUNT_WIDTH(16), .CFG_ADDR_WIDTH(1)) bus1 ();
   readout_rx_state_counter_if #(.COUNT_WIDTH(4),  .CFG_ADDR_WIDTH(1)) bus2 ();

   readout_rx_state_counter #(.COUNT_WIDTH(16), .CFG_ADDR_WIDTH(1), .THRESHOLD_INIT(0)) dut1 (
      .i_clk(clk), .i_rst(rst), .io_bus(bus1));
   readout_rx_state_counter #(.COUNT_WIDTH(4), .CFG_ADDR_WIDTH(1), .THRESHOLD_INIT(0)) dut2 (
      .i_clk(clk), .i_rst(rst), .io_bus(bus2));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus1.i_cfg_wr_en = 0; bus1.i_cfg_wr_addr = 0; bus1.i_cfg_wr_data = 0;
      bus1.i_start_count = 0; bus1.i_finish_count = 0; bus1.i_valid = 0; bus1.i_count_condition = 0;
      bus2.i_cfg_wr_en = 0; bus2.i_cfg_wr_addr = 0; bus2.i_cfg_wr_data = 0;
      bus2.i_start_count = 0; bus2.i_finish_count = 0; bus2.i_valid = 0; bus2.i_count_condition = 0;
   endtask

   task automatic cfg_write(input logic addr, input logic [15:0] data);
      bus1.i_cfg_wr_en = 1; bus1.i_cfg_wr_addr = addr; bus1.i_cfg_wr_data = data;
      step();
      bus1.i_cfg_wr_en = 0;
   endtask

   // One sample on dut1: start/finish/valid/condition for this cycle.
   task automatic sample1(input logic s, input logic f, input logic v, input logic c);
      bus1.i_start_count = s; bus1.i_finish_count = f; bus1.i_valid = v; bus1.i_count_condition = c;
      step();
      bus1.i_start_count = 0; bus1.i_finish_count = 0; bus1.i_valid = 0; bus1.i_count_condition = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      step(); step();
      n_checks++;
      if ({bus1.o_busy, bus1.o_state_valid, bus1.o_state_out, bus1.o_empty_window} !== 4'b0000 ||
          bus1.o_one_count !== 16'd0 || bus1.o_sample_count !== 16'd0) begin
         n_fail++;
         $display("FAIL reset16: busy=%b sv=%b st=%b empty=%b one=%0d smp=%0d, all must be 0",
                  bus1.o_busy, bus1.o_state_valid, bus1.o_state_out, bus1.o_empty_window,
                  bus1.o_one_count, bus1.o_sample_count);
      end
      n_checks++;
      if ({bus2.o_busy, bus2.o_state_valid, bus2.o_state_out, bus2.o_empty_window} !== 4'b0000 ||
          bus2.o_one_count !== 4'd0 || bus2.o_sample_count !== 4'd0) begin
         n_fail++;
         $display("FAIL reset4: one=%0d smp=%0d sv=%b, all must be 0",
                  bus2.o_one_count, bus2.o_sample_count, bus2.o_state_valid);
      end
      rst = 0;
      step();
   endtask

   // Stream 1,0,1,1,0 with finish on the 5th sample; one=3, samples=5.
   task automatic test_threshold(input logic [15:0] thr, input logic exp_state);
      cfg_write(1'b0, thr);
      sample1(1, 0, 1, 1);
      n_checks++;
      if (bus1.o_busy !== 1'b1) begin
         n_fail++; $display("FAIL busy_after_start thr=%0d: got %b need 1", thr, bus1.o_busy);
      end
      sample1(0, 0, 1, 0);
      sample1(0, 0, 1, 1);
      sample1(0, 0, 1, 1);
      sample1(0, 1, 1, 0);
      n_checks++;
      if (bus1.o_state_valid !== 1'b1 || bus1.o_state_out !== exp_state ||
          bus1.o_one_count !== 16'd3 || bus1.o_sample_count !== 16'd5 ||
          bus1.o_empty_window !== 1'b0 || bus1.o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL decision thr=%0d: sv=%b st=%b one=%0d smp=%0d empty=%b busy=%b need 1 %b 3 5 0 0",
                  thr, bus1.o_state_valid, bus1.o_state_out, bus1.o_one_count,
                  bus1.o_sample_count, bus1.o_empty_window, bus1.o_busy, exp_state);
      end
      step();
      n_checks++;
      if (bus1.o_state_valid !== 1'b0 || bus1.o_state_out !== exp_state || bus1.o_one_count !== 16'd3) begin
         n_fail++;
         $display("FAIL pulse_width thr=%0d: sv=%b st=%b one=%0d need 0 %b 3",
                  thr, bus1.o_state_valid, bus1.o_state_out, bus1.o_one_count, exp_state);
      end
   endtask

   task automatic test_auto_close();
      int pulses = 0;
      int at     = 0;
      cfg_write(1'b1, 16'd4);
      cfg_write(1'b0, 16'd2);
      for (int i = 1; i <= 10; i++) begin
         sample1(i == 1, 0, 1, 1);
         if (bus1.o_state_valid === 1'b1) begin pulses++; at = i; end
         if (i == 3) begin
            n_checks++;
            if (bus1.o_busy !== 1'b1) begin
               n_fail++; $display("FAIL auto_busy3: got %b need 1", bus1.o_busy);
            end
         end
         if (i == 4) begin
            n_checks++;
            if (bus1.o_busy !== 1'b0 || bus1.o_one_count !== 16'd4 ||
                bus1.o_sample_count !== 16'd4 || bus1.o_state_out !== 1'b1) begin
               n_fail++;
               $display("FAIL auto_close: busy=%b one=%0d smp=%0d st=%b need 0 4 4 1",
                        bus1.o_busy, bus1.o_one_count, bus1.o_sample_count, bus1.o_state_out);
            end
         end
      end
      n_checks++;
      if (pulses !== 1 || at !== 4) begin
         n_fail++; $display("FAIL auto_pulses: count=%0d at=%0d need 1 at 4", pulses, at);
      end
      cfg_write(1'b1, 16'd0);
   endtask

   task automatic test_restart();
      int pulses = 0;
      sample1(1, 0, 1, 0); if (bus1.o_state_valid === 1'b1) pulses++;
      sample1(0, 0, 1, 0); if (bus1.o_state_valid === 1'b1) pulses++;
      sample1(0, 0, 1, 0); if (bus1.o_state_valid === 1'b1) pulses++;
      sample1(1, 0, 1, 1); if (bus1.o_state_valid === 1'b1) pulses++;
      sample1(0, 1, 1, 1); if (bus1.o_state_valid === 1'b1) pulses++;
      n_checks++;
      if (bus1.o_sample_count !== 16'd2 || bus1.o_one_count !== 16'd2 || bus1.o_state_out !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_counts: smp=%0d one=%0d st=%b need 2 2 1",
                  bus1.o_sample_count, bus1.o_one_count, bus1.o_state_out);
      end
      step(); if (bus1.o_state_valid === 1'b1) pulses++;
      n_checks++;
      if (pulses !== 1) begin
         n_fail++; $display("FAIL restart_pulses: got %0d need 1", pulses);
      end
      // Finish and valid while idle must be ignored.
      for (int i = 0; i < 3; i++) begin
         sample1(0, 1, 1, 1);
         n_checks++;
         if (bus1.o_state_valid !== 1'b0 || bus1.o_busy !== 1'b0 || bus1.o_sample_count !== 16'd2) begin
            n_fail++;
            $display("FAIL idle_finish[%0d]: sv=%b busy=%b smp=%0d need 0 0 2",
                     i, bus1.o_state_valid, bus1.o_busy, bus1.o_sample_count);
         end
      end
   endtask

   task automatic test_empty(input logic [15:0] thr, input logic exp_state);
      cfg_write(1'b0, thr);
      sample1(1, 1, 0, 0);
      n_checks++;
      if (bus1.o_state_valid !== 1'b1 || bus1.o_empty_window !== 1'b1 || bus1.o_state_out !== exp_state ||
          bus1.o_sample_count !== 16'd0 || bus1.o_one_count !== 16'd0) begin
         n_fail++;
         $display("FAIL empty thr=%0d: sv=%b empty=%b st=%b smp=%0d one=%0d need 1 1 %b 0 0",
                  thr, bus1.o_state_valid, bus1.o_empty_window, bus1.o_state_out,
                  bus1.o_sample_count, bus1.o_one_count, exp_state);
      end
      step();
   endtask

   task automatic test_back_to_back();
      cfg_write(1'b0, 16'd1);
      sample1(1, 1, 1, 1);
      n_checks++;
      if (bus1.o_state_valid !== 1'b1 || bus1.o_one_count !== 16'd1 || bus1.o_sample_count !== 16'd1) begin
         n_fail++;
         $display("FAIL b2b_first: sv=%b one=%0d smp=%0d need 1 1 1",
                  bus1.o_state_valid, bus1.o_one_count, bus1.o_sample_count);
      end
      sample1(1, 0, 1, 0);
      n_checks++;
      if (bus1.o_state_valid !== 1'b0 || bus1.o_busy !== 1'b1 || bus1.o_sample_count !== 16'd1) begin
         n_fail++;
         $display("FAIL b2b_restart: sv=%b busy=%b smp=%0d need 0 1 1",
                  bus1.o_state_valid, bus1.o_busy, bus1.o_sample_count);
      end
      sample1(0, 1, 1, 1);
      n_checks++;
      if (bus1.o_state_valid !== 1'b1 || bus1.o_sample_count !== 16'd2 || bus1.o_one_count !== 16'd1 ||
          bus1.o_state_out !== 1'b1 || bus1.o_empty_window !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_second: sv=%b smp=%0d one=%0d st=%b empty=%b need 1 2 1 1 0",
                  bus1.o_state_valid, bus1.o_sample_count, bus1.o_one_count,
                  bus1.o_state_out, bus1.o_empty_window);
      end
      step();
   endtask

   task automatic test_mid_reset();
      int pulses = 0;
      sample1(1, 0, 1, 1);
      sample1(0, 0, 1, 1);
      rst = 1;
      sample1(0, 0, 1, 1);
      n_checks++;
      if ({bus1.o_busy, bus1.o_state_valid, bus1.o_state_out, bus1.o_empty_window} !== 4'b0000 ||
          bus1.o_one_count !== 16'd0 || bus1.o_sample_count !== 16'd0) begin
         n_fail++;
         $display("FAIL mid_reset: busy=%b sv=%b st=%b empty=%b one=%0d smp=%0d, all must be 0",
                  bus1.o_busy, bus1.o_state_valid, bus1.o_state_out, bus1.o_empty_window,
                  bus1.o_one_count, bus1.o_sample_count);
      end
      rst = 0;
      sample1(0, 1, 1, 1); if (bus1.o_state_valid === 1'b1) pulses++;
      step();              if (bus1.o_state_valid === 1'b1) pulses++;
      n_checks++;
      if (pulses !== 0 || bus1.o_busy !== 1'b0) begin
         n_fail++; $display("FAIL post_reset: pulses=%0d busy=%b need 0 0", pulses, bus1.o_busy);
      end
   endtask

   task automatic test_saturation();
      for (int i = 1; i <= 20; i++) begin
         bus2.i_start_count = (i == 1); bus2.i_finish_count = (i == 20);
         bus2.i_valid = 1; bus2.i_count_condition = 1;
         step();
      end
      bus2.i_start_count = 0; bus2.i_finish_count = 0; bus2.i_valid = 0; bus2.i_count_condition = 0;
      n_checks++;
      if (bus2.o_state_valid !== 1'b1 || bus2.o_one_count !== 4'd15 ||
          bus2.o_sample_count !== 4'd15 || bus2.o_state_out !== 1'b1) begin
         n_fail++;
         $display("FAIL saturate: sv=%b one=%0d smp=%0d st=%b need 1 15 15 1",
                  bus2.o_state_valid, bus2.o_one_count, bus2.o_sample_count, bus2.o_state_out);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_threshold(16'd3, 1'b1);
      test_threshold(16'd4, 1'b0);
      test_auto_close();
      cfg_write(1'b0, 16'd2);
      test_restart();
      test_empty(16'd0, 1'b1);
      test_empty(16'd1, 1'b0);
      test_back_to_back();
      test_mid_reset();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
